// File: rtl/spi_arbiter_if.sv
// Request/response and SPI-master control bundle shared by spi_arbiter and its clients.
// Signal names are seen from the arbiter: i_* are driven into it, o_* are driven by it.
interface spi_arbiter_if #(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned SPI_DATA_WIDTH = 32
);
   // Requester side
   logic [NUM_REQUESTERS-1:0]                i_req_valid;
   logic [NUM_REQUESTERS-1:0]                o_req_ready;
   logic [NUM_REQUESTERS*SPI_DATA_WIDTH-1:0] i_req_data;
   logic [NUM_REQUESTERS-1:0]                o_rsp_valid;
   logic [SPI_DATA_WIDTH-1:0]                o_rsp_data;
   logic                                     o_rsp_error;
   logic [NUM_REQUESTERS-1:0]                o_grant;
   logic                                     o_busy;

   // SPI master control port
   logic                                     o_spi_enable;
   logic [SPI_DATA_WIDTH-1:0]                o_spi_data;
   logic [SPI_DATA_WIDTH-1:0]                i_spi_data;
   logic                                     i_spi_done;
   logic                                     i_spi_busy;

   // Arbiter side
   modport master (
      input  i_req_valid, i_req_data, i_spi_data, i_spi_done, i_spi_busy,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_error, o_grant, o_busy,
             o_spi_enable, o_spi_data
   );

   // Requesters plus SPI master core
   modport slave (
      output i_req_valid, i_req_data, i_spi_data, i_spi_done, i_spi_busy,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_error, o_grant, o_busy,
             o_spi_enable, o_spi_data
   );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master core among NUM_REQUESTERS clients.
// Optional WAIT_DONE watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned SPI_DATA_WIDTH = 32
`ifdef SPI_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input logic           i_clock,
   input logic           i_reset,
   spi_arbiter_if.master bus
);
   localparam int unsigned N     = NUM_REQUESTERS;
   localparam int unsigned W     = SPI_DATA_WIDTH;
   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_DONE,
      ST_RESPOND
   } state_e;

   state_e           state_q,     state_d;
   logic [PTR_W-1:0] last_q,      last_d;
   logic [PTR_W-1:0] gidx_q,      gidx_d;
   logic [N-1:0]     grant_q,     grant_d;
   logic [W-1:0]     tx_q,        tx_d;
   logic [W-1:0]     rsp_data_q,  rsp_data_d;
   logic             rsp_error_q, rsp_error_d;
   logic [N-1:0]     rsp_valid_q, rsp_valid_d;
   logic             enable_q,    enable_d;
   logic             busy_q,      busy_d;
   logic [N-1:0]     ready_c;
`ifdef SPI_ARB_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
`endif

   logic             pick_any;
   logic             pick_hi_found;
   logic [PTR_W-1:0] pick_hi;
   logic [PTR_W-1:0] pick_lo;
   logic [PTR_W-1:0] pick_idx;

   // Round-robin pick: lowest valid index above last, else lowest valid index overall
   always_comb begin
      pick_any      = 1'b0;
      pick_hi_found = 1'b0;
      pick_hi       = '0;
      pick_lo       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (bus.i_req_valid[k] && !pick_any) begin
            pick_any = 1'b1;
            pick_lo  = PTR_W'(k);
         end
         if (bus.i_req_valid[k] && (k > 32'(last_q)) && !pick_hi_found) begin
            pick_hi_found = 1'b1;
            pick_hi       = PTR_W'(k);
         end
      end
      pick_idx = pick_hi_found ? pick_hi : pick_lo;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gidx_d      = gidx_q;
      grant_d     = grant_q;
      tx_d        = tx_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;
      ready_c     = '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.i_spi_busy && pick_any) begin
               ready_c[pick_idx] = 1'b1;
               gidx_d            = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               tx_d              = bus.i_req_data[pick_idx*W +: W];
               state_d           = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // Done wins over an expiry in the same cycle
            if (bus.i_spi_done) begin
               rsp_data_d  = bus.i_spi_data;
               rsp_error_d = 1'b0;
               state_d     = ST_RESPOND;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
               state_d     = ST_RESPOND;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
`endif
         end
         ST_RESPOND: begin
            last_d  = gidx_q;
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      enable_d    = (state_d == ST_LAUNCH);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_RESPOND) ? grant_q : '0;
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         last_q      <= PTR_W'(N - 1);
         gidx_q      <= '0;
         grant_q     <= '0;
         tx_q        <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
         rsp_valid_q <= '0;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gidx_q      <= gidx_d;
         grant_q     <= grant_d;
         tx_q        <= tx_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         rsp_valid_q <= rsp_valid_d;
         enable_q    <= enable_d;
         busy_q      <= busy_d;
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   // WAIT_DONE watchdog counter
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   // The accept is combinational; masked so every output reads 0 while reset is held
   assign bus.o_req_ready  = ready_c & {N{~i_reset}};
   assign bus.o_rsp_valid  = rsp_valid_q;
   assign bus.o_rsp_data   = rsp_data_q;
   assign bus.o_rsp_error  = rsp_error_q;
   assign bus.o_grant      = grant_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_spi_enable = enable_q;
   assign bus.o_spi_data   = tx_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed vectors, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_spi_arbiter;
   localparam int unsigned N           = 4;
   localparam int unsigned W           = 32;
   localparam int unsigned IW          = 2;
   localparam int unsigned TO          = 64;
   localparam int          RAND_CYCLES = 3000;

   typedef struct {
      int           prev;
      logic [N-1:0] mask;
      logic [N-1:0] exp;
   } arb_vec_t;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   int       n_cmp = 0;
   int       n_bad = 0;
   logic [W-1:0] word [N];
   arb_vec_t vecs [8];

   always #5 clk = ~clk;

   spi_arbiter_if #(.NUM_REQUESTERS(N), .SPI_DATA_WIDTH(W)) bus ();

   spi_arbiter #(
      .NUM_REQUESTERS(N),
      .SPI_DATA_WIDTH(W)
`ifdef SPI_ARB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus    (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_data();
      for (int k = 0; k < int'(N); k++) bus.i_req_data[k*W +: W] = word[IW'(k)];
   endtask

   function automatic logic [N-1:0] onehot(input int idx);
      return N'(1) << idx;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int k = 0; k < int'(N); k++) if (v[IW'(k)]) return k;
      return 0;
   endfunction

   // Reference rule: first valid requester searching from last+1, wrapping
   function automatic int model_pick(input logic [N-1:0] valid, input int last);
      for (int i = 1; i <= int'(N); i++) begin
         if (valid[IW'((last + i) % int'(N))]) return (last + i) % int'(N);
      end
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, " ready"},     bus.o_req_ready,  0);
      check({tag, " grant"},     bus.o_grant,      0);
      check({tag, " busy"},      bus.o_busy,       0);
      check({tag, " enable"},    bus.o_spi_enable, 0);
      check({tag, " rsp_valid"}, bus.o_rsp_valid,  0);
      check({tag, " rsp_data"},  bus.o_rsp_data,   0);
      check({tag, " rsp_error"}, bus.o_rsp_error,  0);
      check({tag, " spi_data"},  bus.o_spi_data,   0);
   endtask

   // Asserts reset away from the clock edge, checks the asynchronous clear, then releases
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check_zero(tag);
      bus.i_req_valid = '0;
      bus.i_spi_done  = 1'b0;
      bus.i_spi_busy  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One complete transaction that must be accepted in the current cycle (T)
   task automatic do_txn(input string tag, input logic [N-1:0] exp_g, input int lat,
                         input logic [W-1:0] rx);
      int g;
      g = idx_of(exp_g);
      #1;
      check({tag, " accept"}, bus.o_req_ready, exp_g);
      tick();
      check({tag, " enable"},  bus.o_spi_enable, 1);
      check({tag, " tx word"}, bus.o_spi_data,   word[IW'(g)]);
      check({tag, " grant"},   bus.o_grant,      exp_g);
      check({tag, " busy"},    bus.o_busy,       1);
      repeat (lat) tick();
      bus.i_spi_done = 1'b1;
      bus.i_spi_data = rx;
      #1;
      check({tag, " early rsp"}, bus.o_rsp_valid, 0);
      tick();
      bus.i_spi_done = 1'b0;
      #1;
      check({tag, " rsp_valid"}, bus.o_rsp_valid, exp_g);
      check({tag, " rsp_data"},  bus.o_rsp_data,  rx);
      check({tag, " rsp_error"}, bus.o_rsp_error, 0);
      tick();
      #1;
      check({tag, " grant clear"}, bus.o_grant, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] rv;
      logic [N-1:0] exp_ready;
      logic [W-1:0] m_tx, m_tx_new, m_rsp, m_rx;
      int           m_last, m_g, m_acc, m_done, pick;
      bit           m_active, sb, in_window, waiting;

      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      bus.i_spi_data  = '0;
      bus.i_spi_done  = 1'b0;
      bus.i_spi_busy  = 1'b0;
      for (int k = 0; k < int'(N); k++) word[IW'(k)] = $urandom;
      drive_data();

      vecs[0] = '{1, 4'b1010, 4'b1000};
      vecs[1] = '{3, 4'b1010, 4'b0010};
      vecs[2] = '{0, 4'b1111, 4'b0010};
      vecs[3] = '{2, 4'b0101, 4'b0001};
      vecs[4] = '{3, 4'b1000, 4'b1000};
      vecs[5] = '{2, 4'b0100, 4'b0100};
      vecs[6] = '{0, 4'b0011, 4'b0010};
      vecs[7] = '{1, 4'b0011, 4'b0001};

      tick();
      apply_reset("reset");

      // Single transaction, no contention
      word[2] = 32'hA5A5_0001;
      drive_data();
      bus.i_req_valid = 4'b0100;
      do_txn("single", 4'b0100, 40, 32'h1234_5678);
      bus.i_req_valid = '0;

      // Rotation from reset with everyone valid
      apply_reset("rot reset");
      bus.i_req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) do_txn($sformatf("rot%0d", i), onehot(i % int'(N)), 3 + i, $urandom);
      bus.i_req_valid = '0;

      // Pointer continuity
      bus.i_req_valid = 4'b0010;
      do_txn("ptr g1", 4'b0010, 4, $urandom);
      bus.i_req_valid = 4'b1010;
      do_txn("ptr g3", 4'b1000, 2, $urandom);
      do_txn("ptr g1b", 4'b0010, 6, $urandom);
      bus.i_req_valid = '0;

      // Arbitration vectors: prime the pointer with a solo grant, then present a mask
      foreach (vecs[i]) begin
         bus.i_req_valid = onehot(vecs[i].prev);
         do_txn($sformatf("vec%0d prime", i), onehot(vecs[i].prev), 2, $urandom);
         bus.i_req_valid = vecs[i].mask;
         do_txn($sformatf("vec%0d", i), vecs[i].exp, 1 + i, $urandom);
         bus.i_req_valid = '0;
      end

      // Busy gating
      bus.i_spi_busy  = 1'b1;
      bus.i_req_valid = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         #1;
         check($sformatf("busy gate c%0d", i), bus.o_req_ready, 0);
         tick();
      end
      bus.i_spi_busy = 1'b0;
      do_txn("busy release", 4'b0001, 3, 32'h5555_AAAA);
      bus.i_req_valid = '0;

      // Reset while waiting for done
      bus.i_req_valid = 4'b0010;
      #1;
      check("mid accept", bus.o_req_ready, 4'b0010);
      tick();
      tick();
      tick();
      check("mid busy", bus.o_busy, 1);
      apply_reset("midflight");
      bus.i_req_valid = 4'b1001;
      do_txn("post reset", 4'b0001, 5, 32'h0BAD_CAFE);
      bus.i_req_valid = '0;

`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog expiry without done
      bus.i_req_valid = 4'b0100;
      #1;
      check("to accept", bus.o_req_ready, 4'b0100);
      tick();
      bus.i_req_valid = '0;
      repeat (TO) tick();
      check("to early", bus.o_rsp_valid, 0);
      tick();
      check("to rsp_valid", bus.o_rsp_valid, 4'b0100);
      check("to rsp_error", bus.o_rsp_error, 1);
      check("to rsp_data",  bus.o_rsp_data,  0);
      tick();
      // Done landing in the expiry cycle wins
      bus.i_req_valid = 4'b0100;
      #1;
      check("to2 accept", bus.o_req_ready, 4'b0100);
      tick();
      bus.i_req_valid = '0;
      repeat (TO) tick();
      bus.i_spi_done = 1'b1;
      bus.i_spi_data = 32'hCAFE_F00D;
      tick();
      bus.i_spi_done = 1'b0;
      #1;
      check("to2 rsp_valid", bus.o_rsp_valid, 4'b0100);
      check("to2 rsp_error", bus.o_rsp_error, 0);
      check("to2 rsp_data",  bus.o_rsp_data,  32'hCAFE_F00D);
      tick();
`endif

      // Randomized traffic against the transaction-level model
      apply_reset("rand reset");
      rv       = '0;
      m_last   = int'(N) - 1;
      m_active = 1'b0;
      m_tx     = '0;
      m_tx_new = '0;
      m_rsp    = '0;
      m_rx     = '0;
      m_g      = 0;
      m_acc    = 0;
      m_done   = 0;
      for (int c = 0; c < RAND_CYCLES; c++) begin
         for (int k = 0; k < int'(N); k++) begin
            if (!rv[IW'(k)]) begin
               if ($urandom_range(0, 2) == 0) begin
                  rv[IW'(k)]   = 1'b1;
                  word[IW'(k)] = $urandom;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               rv[IW'(k)] = 1'b0;
            end
         end
         bus.i_req_valid = rv;
         drive_data();
         sb        = ($urandom_range(0, 4) == 0);
         in_window = m_active && (c >= m_acc + 1) && (c <= m_done + 1);
         waiting   = m_active && (c >= m_acc + 2) && (c <= m_done);
         if (m_active && c == m_done) begin
            m_rx           = $urandom;
            bus.i_spi_done = 1'b1;
            bus.i_spi_data = m_rx;
         end else begin
            bus.i_spi_done = !waiting && ($urandom_range(0, 7) == 0);
            bus.i_spi_data = $urandom;
         end
         bus.i_spi_busy = sb;
         #1;

         if (m_active && c == m_acc + 1) m_tx = m_tx_new;
         if (m_active && c == m_done + 1) m_rsp = m_rx;
         pick      = model_pick(rv, m_last);
         exp_ready = (!in_window && !sb && pick >= 0) ? onehot(pick) : '0;
         check("rnd ready",     bus.o_req_ready,  exp_ready);
         check("rnd enable",    bus.o_spi_enable, m_active && c == m_acc + 1);
         check("rnd grant",     bus.o_grant,      in_window ? onehot(m_g) : '0);
         check("rnd busy",      bus.o_busy,       in_window);
         check("rnd rsp_valid", bus.o_rsp_valid,
               (m_active && c == m_done + 1) ? onehot(m_g) : '0);
         check("rnd rsp_data",  bus.o_rsp_data,   m_rsp);
         check("rnd rsp_error", bus.o_rsp_error,  0);
         check("rnd spi_data",  bus.o_spi_data,   m_tx);

         if (m_active && c == m_done + 1) m_last = m_g;
         if (exp_ready != '0) begin
            m_active    = 1'b1;
            m_acc       = c;
            m_g         = pick;
            m_tx_new    = word[IW'(pick)];
            m_done      = c + 1 + int'($urandom_range(1, 12));
            rv[IW'(pick)] = 1'b0;
         end
         tick();
      end
      bus.i_req_valid = '0;
      bus.i_spi_done  = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one SPI master core among NUM_REQUESTERS clients.
- Sits between the requesters (driver/sequencer blocks) and the SPI master's enable/data/done/busy control port.
- Accepts one full-width word per transaction, launches it on the master, and returns the received word to the granted requester.

Parameters:
- NUM_REQUESTERS, 4, number of client ports (>=1).
- SPI_DATA_WIDTH, 32, transfer word width.
- TIMEOUT_CYCLES, 1024, WAIT_DONE watchdog limit. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_req_valid  in  NUM_REQUESTERS  per-client request valid.
- o_req_ready  out  NUM_REQUESTERS  per-client accept, one-hot.
- i_req_data  in  NUM_REQUESTERS*SPI_DATA_WIDTH  client words; client k occupies bits [k*W +: W].
- o_rsp_valid  out  NUM_REQUESTERS  one-cycle response strobe, one-hot.
- o_rsp_data  out  SPI_DATA_WIDTH  shared response word.
- o_rsp_error  out  1  response timed out.
- o_grant  out  NUM_REQUESTERS  one-hot owner of the current transaction.
- o_busy  out  1  high whenever the state is not IDLE.
- o_spi_enable  out  1  one-cycle launch pulse to the master.
- o_spi_data  out  SPI_DATA_WIDTH  word to transmit.
- i_spi_data  in  SPI_DATA_WIDTH  received word; valid when i_spi_done is high.
- i_spi_done  in  1  one-cycle completion pulse.
- i_spi_busy  in  1  master is transferring.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer "last" = NUM_REQUESTERS-1, so requester 0 wins the first arbitration.
- Reset mid-transaction aborts immediately. The requester is not notified.
- The state machine has four states: IDLE, LAUNCH, WAIT_DONE, RESPOND.
- IDLE:
  - If i_spi_busy=0 and any i_req_valid is high, select the first valid requester searching from last+1, wrapping modulo NUM_REQUESTERS.
  - o_req_ready[g] is asserted combinationally in that same cycle (cycle T); this is the accept.
  - Register o_spi_data from the selected slice and set o_grant, then go to LAUNCH.
  - While i_spi_busy=1, no ready is asserted.
- LAUNCH (T+1): o_spi_enable=1 for exactly one cycle, then go to WAIT_DONE. o_spi_data stays stable until RESPOND ends.
- WAIT_DONE:
  - On i_spi_done in cycle D, capture i_spi_data into o_rsp_data, set o_rsp_error=0, and go to RESPOND.
- RESPOND (D+1):
  - o_rsp_valid[g]=1 for one cycle; o_rsp_data is valid in that cycle and held until the next capture.
  - Update last=g and go to IDLE.
  - o_grant clears on leaving RESPOND.
- The earliest next accept is D+2.
- Requester handshake rules:
  - A requester must hold valid and data stable until it sees ready.
  - Dropping valid before the grant is legal and has no effect.
  - There is no response backpressure; the requester must sample o_rsp_valid.
- i_spi_done outside WAIT_DONE is ignored.
- With NUM_REQUESTERS=1, selection is always index 0. Pointer width is clog2(NUM_REQUESTERS), with a minimum of 1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,N-1,0. No requester waits more than N-1 transactions.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 without i_spi_done, go to RESPOND with o_rsp_error=1 and o_rsp_data=0.
  - o_rsp_valid then occurs at T+2+TIMEOUT_CYCLES.
  - If i_spi_done arrives in the expiry cycle, done wins and o_rsp_error=0.
  - The following grant is still gated by i_spi_busy=0.
- Undefined: no counter; WAIT_DONE waits indefinitely; o_rsp_error is constant 0.

Test Plan:
- Single transaction, no contention:
  - Stimulus: requester 2 presents 0xA5A50001; master model returns 0x12345678 with done 40 cycles after the enable pulse.
  - Response: o_req_ready[2] in the same cycle T; o_spi_enable at T+1 with o_spi_data=0xA5A50001; o_rsp_valid=4'b0100 at D+1 with o_rsp_data=0x12345678 and o_rsp_error=0.
- Rotation: all 4 requesters held valid for 5 transactions -> grant sequence 0,1,2,3,0, each accept exactly D+2 after the previous done.
- Pointer continuity: after a grant to 1, requesters 3 and 1 are both valid -> next grant 3, then 1.
- Busy gating: i_spi_busy=1 in IDLE for 20 cycles with requester 0 valid -> no o_req_ready; ready asserts in the first cycle busy is low.
- Reset mid-flight: i_reset in WAIT_DONE -> all outputs 0 asynchronously; after release, with requesters 0 and 3 valid, requester 0 is granted first.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64):
  - No done -> o_rsp_valid at T+66 with o_rsp_error=1 and o_rsp_data=0.
  - Done exactly in the expiry cycle -> o_rsp_error=0 with the captured data.
